// File: rtl/definitions.sv
// Shared FSM state type and program address tables for the program sequencer.
package definitions;

    localparam int TABLE_PC_BITS = 9;
    localparam int TABLE_PROGS   = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        RECORD,
        FINISH
    } seq_state_t;

    // First and last instruction address of each program in instruction memory.
    localparam logic [TABLE_PC_BITS-1:0] PROG_START [TABLE_PROGS] = '{9'd0, 9'd145, 9'd290};
    localparam logic [TABLE_PC_BITS-1:0] PROG_DONE  [TABLE_PROGS] = '{9'd144, 9'd289, 9'd435};

endpackage

// File: rtl/run_counter.sv
// Saturating up-counter with synchronous clear; exposes the value being loaded
// this cycle and flags when that value reaches LIMIT.
module run_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] LIMIT = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] next_o,
    output logic             terminal_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Hold at all-ones rather than wrap, so a very long run never reads as a short one.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign next_o     = count_d;
    assign terminal_o = (count_d >= LIMIT);

endmodule

// File: rtl/program_sequencer.sv
// Run controller: steps the core through each program in turn, holding it in start
// between programs, and reports the RUN cycle count of every completed program.
module program_sequencer
    import definitions::*;
#(
    parameter int                  PC_BITS      = 9,
    parameter int                  NUM_PROGS    = 3,
    parameter int                  CNT_BITS     = 16,
    parameter int                  START_CYCLES = 2,
    parameter logic [CNT_BITS-1:0] TIMEOUT      = 16'hFFFF
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         go,
    input  logic                         abort,
    input  logic                         core_done,
    output logic                         core_start,
    output logic [PC_BITS-1:0]           start_addr,
    output logic [PC_BITS-1:0]           done_addr,
    output logic [$clog2(NUM_PROGS)-1:0] prog_idx,
    output logic                         busy,
    output logic                         cycle_valid,
    output logic [CNT_BITS-1:0]          cycle_count,
    output logic                         all_done,
    output logic                         timeout_err
);

    localparam int                  IDX_BITS = $clog2(NUM_PROGS);
    localparam int                  SC_BITS  = $clog2(START_CYCLES + 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_PROGS - 1);

    seq_state_t            state_q;
    logic                  go_q;
    logic                  goRise_q;
    logic                  coreStart_q;
    logic [PC_BITS-1:0]    startAddr_q;
    logic [PC_BITS-1:0]    doneAddr_q;
    logic [IDX_BITS-1:0]   progIdx_q;
    logic                  busy_q;
    logic                  cycleValid_q;
    logic [CNT_BITS-1:0]   cycleCount_q;
    logic                  allDone_q;
    logic                  timeoutErr_q;

    logic [IDX_BITS-1:0]   nextIdx;
    logic                  startDone;
    logic                  runLimit;
    logic [SC_BITS-1:0]    unusedStartNext;
    logic [CNT_BITS-1:0]   runNext;

    assign nextIdx = progIdx_q + IDX_BITS'(1);

    run_counter #(
        .WIDTH (SC_BITS),
        .LIMIT (SC_BITS'(START_CYCLES))
    ) startCounter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (state_q != START),
        .enable_i   (state_q == START),
        .next_o     (unusedStartNext),
        .terminal_o (startDone)
    );

    // runNext already includes the cycle in which core_done is sampled.
    run_counter #(
        .WIDTH (CNT_BITS),
        .LIMIT (TIMEOUT)
    ) runCounter (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_i    (state_q != RUN),
        .enable_i   (state_q == RUN),
        .next_o     (runNext),
        .terminal_o (runLimit)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            go_q         <= 1'b0;
            goRise_q     <= 1'b0;
            coreStart_q  <= 1'b1;
            startAddr_q  <= PC_BITS'(PROG_START[0]);
            doneAddr_q   <= PC_BITS'(PROG_DONE[0]);
            progIdx_q    <= '0;
            busy_q       <= 1'b0;
            cycleValid_q <= 1'b0;
            cycleCount_q <= '0;
            allDone_q    <= 1'b0;
            timeoutErr_q <= 1'b0;
        end else begin
            go_q         <= go;
            goRise_q     <= go & ~go_q;
            cycleValid_q <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                coreStart_q <= 1'b1;
                busy_q      <= 1'b0;
                allDone_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, FINISH: begin
                        if (goRise_q) begin
                            state_q      <= START;
                            progIdx_q    <= '0;
                            startAddr_q  <= PC_BITS'(PROG_START[0]);
                            doneAddr_q   <= PC_BITS'(PROG_DONE[0]);
                            timeoutErr_q <= 1'b0;
                            allDone_q    <= 1'b0;
                            busy_q       <= 1'b1;
                            coreStart_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (startDone) begin
                            state_q     <= RUN;
                            coreStart_q <= 1'b0;
                        end
                    end
                    // A done in the same cycle as the limit still counts as a completion.
                    RUN: begin
                        if (core_done) begin
                            state_q      <= RECORD;
                            cycleValid_q <= 1'b1;
                            cycleCount_q <= runNext;
                            coreStart_q  <= 1'b1;
                        end else if (runLimit) begin
                            state_q      <= FINISH;
                            timeoutErr_q <= 1'b1;
                            allDone_q    <= 1'b1;
                            busy_q       <= 1'b0;
                            coreStart_q  <= 1'b1;
                        end
                    end
                    RECORD: begin
                        if (progIdx_q == LAST_IDX) begin
                            state_q   <= FINISH;
                            allDone_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            state_q     <= START;
                            progIdx_q   <= nextIdx;
                            startAddr_q <= PC_BITS'(PROG_START[nextIdx]);
                            doneAddr_q  <= PC_BITS'(PROG_DONE[nextIdx]);
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        coreStart_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign core_start  = coreStart_q;
    assign start_addr  = startAddr_q;
    assign done_addr   = doneAddr_q;
    assign prog_idx    = progIdx_q;
    assign busy        = busy_q;
    assign cycle_valid = cycleValid_q;
    assign cycle_count = cycleCount_q;
    assign all_done    = allDone_q;
    assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a small core model answers core_start,
// stimulus queues expected cycle counts and a forked monitor checks every pulse.
module tb_program_sequencer;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b0;
    logic        go          = 1'b0;
    logic        abort       = 1'b0;
    logic        core_done   = 1'b0;
    logic        core_start;
    logic [8:0]  start_addr;
    logic [8:0]  done_addr;
    logic [1:0]  prog_idx;
    logic        busy;
    logic        cycle_valid;
    logic [15:0] cycle_count;
    logic        all_done;
    logic        timeout_err;

    typedef struct {
        int idx;
        int count;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;
    int   progLen [3] = '{0, 0, 0};
    bit   holdDone = 1'b0;
    int   runSeen = 0;
    int   lastRunLen = 0;
    int   expStart [3] = '{0, 145, 290};
    int   expDone  [3] = '{144, 289, 435};

    program_sequencer #(
        .PC_BITS      (9),
        .NUM_PROGS    (3),
        .CNT_BITS     (16),
        .START_CYCLES (2),
        .TIMEOUT      (16'd100)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .go          (go),
        .abort       (abort),
        .core_done   (core_done),
        .core_start  (core_start),
        .start_addr  (start_addr),
        .done_addr   (done_addr),
        .prog_idx    (prog_idx),
        .busy        (busy),
        .cycle_valid (cycle_valid),
        .cycle_count (cycle_count),
        .all_done    (all_done),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    // Core model: raises done in the Nth RUN cycle of a program (N=0 never finishes).
    // With holdDone set, done stays high between programs until the next RUN begins.
    always @(negedge clock) begin
        if (core_start === 1'b0) begin
            runSeen = runSeen + 1;
            if (runSeen == 1) begin
                core_done = 1'b0;
            end
            if (progLen[int'(prog_idx)] != 0 && runSeen == progLen[int'(prog_idx)]) begin
                core_done = 1'b1;
            end
        end else begin
            if (runSeen != 0) begin
                lastRunLen = runSeen;
            end
            runSeen = 0;
            if (!(holdDone && busy === 1'b1)) begin
                core_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int idx, input int count);
        exp_t e;
        e.idx   = idx;
        e.count = count;
        expQ.push_back(e);
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clock);
            if (cycle_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected cycle_valid: got count %0d prog %0d, required no pulse",
                             int'(cycle_count), int'(prog_idx));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("cycle_count", int'(cycle_count), e.count);
                    checkOutput("prog_idx at pulse", int'(prog_idx), e.idx);
                    checkOutput("start_addr at pulse", int'(start_addr), expStart[e.idx]);
                    checkOutput("done_addr at pulse", int'(done_addr), expDone[e.idx]);
                end
            end
        end
    endtask

    task automatic applyStimulus(input int l0, input int l1, input int l2, input bit hold);
        progLen[0] = l0;
        progLen[1] = l1;
        progLen[2] = l2;
        holdDone   = hold;
    endtask

    task automatic pulseGo();
        @(negedge clock);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
    endtask

    task automatic waitBusy(input bit level, input int budget, input string name);
        int n = 0;
        while (busy !== level && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, int'(busy), int'(level));
    endtask

    task automatic waitRunOf(input int idx, input int budget, input string name);
        int n = 0;
        while (!(int'(prog_idx) == idx && core_start === 1'b0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, (int'(prog_idx) == idx && core_start === 1'b0) ? 1 : 0, 1);
    endtask

    task automatic runAndWait(input string tag);
        pulseGo();
        waitBusy(1'b1, 10, {tag, " busy rises"});
        checkOutput({tag, " all_done cleared"}, int'(all_done), 0);
        checkOutput({tag, " prog_idx restart"}, int'(prog_idx), 0);
        waitBusy(1'b0, 2000, {tag, " busy falls"});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " core_start"}, int'(core_start), 1);
        checkOutput({tag, " start_addr"}, int'(start_addr), 0);
        checkOutput({tag, " done_addr"}, int'(done_addr), 144);
        checkOutput({tag, " prog_idx"}, int'(prog_idx), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " cycle_valid"}, int'(cycle_valid), 0);
        checkOutput({tag, " cycle_count"}, int'(cycle_count), 0);
        checkOutput({tag, " all_done"}, int'(all_done), 0);
        checkOutput({tag, " timeout_err"}, int'(timeout_err), 0);
    endtask

    initial begin
        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clock);
        checkResetValues("power-up");
        reset_n = 1'b1;
        @(negedge clock);

        // Normal run with first-transaction latency checks around go.
        $display("[TB] normal run 50/80/20");
        applyStimulus(50, 80, 20, 1'b0);
        pushExp(0, 50);
        pushExp(1, 80);
        pushExp(2, 20);
        @(negedge clock);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        checkOutput("busy while go_rise registers", int'(busy), 0);
        @(negedge clock);
        checkOutput("busy in first START", int'(busy), 1);
        checkOutput("core_start first START", int'(core_start), 1);
        checkOutput("start_addr prog0", int'(start_addr), 0);
        checkOutput("done_addr prog0", int'(done_addr), 144);
        @(negedge clock);
        checkOutput("core_start last START", int'(core_start), 1);
        @(negedge clock);
        checkOutput("core_start first RUN", int'(core_start), 0);
        waitBusy(1'b0, 2000, "normal run busy falls");
        checkOutput("normal all_done", int'(all_done), 1);
        checkOutput("normal timeout_err", int'(timeout_err), 0);
        checkOutput("normal final prog_idx", int'(prog_idx), 2);
        checkOutput("normal FINISH core_start", int'(core_start), 1);

        // core_done left high from the previous program must be ignored in START.
        $display("[TB] done held into START");
        applyStimulus(30, 40, 10, 1'b1);
        pushExp(0, 30);
        pushExp(1, 40);
        pushExp(2, 10);
        runAndWait("hold");
        checkOutput("hold all_done", int'(all_done), 1);
        holdDone = 1'b0;

        // go held high after FINISH must not restart; a fresh rising edge must.
        $display("[TB] go level vs edge");
        applyStimulus(5, 6, 7, 1'b0);
        pushExp(0, 5);
        pushExp(1, 6);
        pushExp(2, 7);
        @(negedge clock);
        go = 1'b1;
        waitBusy(1'b1, 10, "held-go busy rises");
        waitBusy(1'b0, 1000, "held-go busy falls");
        repeat (20) @(negedge clock);
        checkOutput("held go no restart busy", int'(busy), 0);
        checkOutput("held go all_done stays", int'(all_done), 1);
        go = 1'b0;
        applyStimulus(7, 6, 5, 1'b0);
        pushExp(0, 7);
        pushExp(1, 6);
        pushExp(2, 5);
        @(negedge clock);
        go = 1'b1;
        waitBusy(1'b1, 10, "re-go busy rises");
        checkOutput("re-go all_done cleared", int'(all_done), 0);
        waitBusy(1'b0, 1000, "re-go busy falls");
        go = 1'b0;

        // Program 1 hangs: timeout after 100 RUN cycles, no pulse for it.
        $display("[TB] timeout");
        applyStimulus(25, 0, 9, 1'b0);
        pushExp(0, 25);
        runAndWait("timeout");
        checkOutput("timeout_err set", int'(timeout_err), 1);
        checkOutput("timeout all_done", int'(all_done), 1);
        checkOutput("timeout prog_idx", int'(prog_idx), 1);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("timeout_err kept by abort", int'(timeout_err), 1);
        checkOutput("abort from FINISH busy", int'(busy), 0);
        checkOutput("hung program RUN length", lastRunLen, 100);

        // Abort mid-RUN of program 1, then restart from program 0.
        $display("[TB] abort");
        applyStimulus(15, 60, 12, 1'b0);
        pushExp(0, 15);
        pulseGo();
        waitBusy(1'b1, 10, "abort run busy rises");
        checkOutput("timeout_err cleared by go", int'(timeout_err), 0);
        waitRunOf(1, 500, "reach RUN of prog1");
        repeat (10) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort core_start", int'(core_start), 1);
        repeat (5) @(negedge clock);
        checkOutput("idle after abort", int'(busy), 0);
        applyStimulus(11, 12, 13, 1'b0);
        pushExp(0, 11);
        pushExp(1, 12);
        pushExp(2, 13);
        runAndWait("after abort");

        // Reset pulse mid-RUN returns every output to its reset value.
        $display("[TB] reset mid-run");
        applyStimulus(40, 40, 40, 1'b0);
        pulseGo();
        waitBusy(1'b1, 10, "reset run busy rises");
        waitRunOf(0, 50, "reach RUN of prog0");
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkResetValues("mid-run reset");
        repeat (5) @(negedge clock);
        checkOutput("idle after reset", int'(busy), 0);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Run controller that sequences the single-cycle core through its program set without testbench intervention. For each program it loads the start and done addresses, holds the core in start, releases it, waits for the core's `done`, and reports the cycle count. Sits above the core top level: drives the core's `start`, `startingAddress` and `doneAddress`, and observes the core's `done`.

## Interface
- `PC_BITS`, 9: program counter width; matches the core.
- `NUM_PROGS`, 3: number of programs run per `go`.
- `CNT_BITS`, 16: cycle counter width.
- `START_CYCLES`, 2: cycles `core_start` is held high before each program.
- `TIMEOUT`, 16'hFFFF: RUN cycles allowed before a program is declared hung.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `go` in 1: run request; acted on at its rising edge.
- `abort` in 1: forces return to IDLE.
- `core_done` in 1: core's `done`.
- `core_start` out 1: core's `start`.
- `start_addr` out PC_BITS: core `startingAddress`.
- `done_addr` out PC_BITS: core `doneAddress`.
- `prog_idx` out $clog2(NUM_PROGS): current program.
- `busy` out 1: high in every state except IDLE and FINISH.
- `cycle_valid` out 1: one-cycle pulse; `cycle_count` is valid.
- `cycle_count` out CNT_BITS: RUN cycles of the program just completed.
- `all_done` out 1: all programs finished; held high.
- `timeout_err` out 1: sticky hang flag.

## Operation
- `go_rise = go & ~go_q`; `go_q` is a registered copy of `go`.
- FSM states: IDLE, START, RUN, RECORD, FINISH.
- **IDLE**
  - `core_start`=1, so the core is held in start.
  - On `go_rise`: `prog_idx`←0, clear `timeout_err`, clear the start counter, go to START.
- **START**
  - `core_start`=1.
  - `start_addr`/`done_addr` come from the package tables indexed by `prog_idx`.
  - `core_done` is ignored here, because it may still be high from the previous program.
  - After START_CYCLES cycles: go to RUN, with `run_cnt`←0.
- **RUN**
  - `core_start`=0.
  - `run_cnt` increments every cycle, including the cycle in which `core_done` is sampled high.
  - On `core_done`: go to RECORD.
  - When `run_cnt` reaches TIMEOUT without `core_done`: `timeout_err`←1, go to FINISH.
  - `core_done` has priority over timeout in the same cycle.
- **RECORD** (one cycle)
  - `cycle_valid`=1, `cycle_count`=`run_cnt`.
  - If `prog_idx`==NUM_PROGS-1: go to FINISH.
  - Otherwise: `prog_idx`++, go to START.
- **FINISH**
  - `all_done`=1, `core_start`=1.
  - On `go_rise`: restart exactly as from IDLE; `all_done` clears.
- **abort**: from any state, go to IDLE next cycle. `abort` has priority over every other transition, including `go_rise`. `timeout_err` is kept.
- `run_cnt` saturates at its maximum value; it never wraps.
- `cycle_count` holds its last value between pulses.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE
  - `core_start`=1
  - `start_addr`=PROG_START[0], `done_addr`=PROG_DONE[0]
  - `prog_idx`=0
  - `busy`=0, `cycle_valid`=0, `cycle_count`=0, `all_done`=0, `timeout_err`=0
- Reset mid-run behaves identically to power-up reset.
- `go` rises at cycle t: `go_rise` at t+1, state START at t+2. `core_start` stays high through START_CYCLES cycles and is first low in the first RUN cycle.
- `core_done` sampled high at cycle t: `cycle_valid` high at t+1, next START (or FINISH) at t+2.
- `start_addr`/`done_addr` change on entry to START and are stable while `core_start`=1 and throughout RUN.
- Per-program overhead between programs is START_CYCLES+1 cycles.

## Structure
- Shared package `definitions` holds:
  - state enum `seq_state_t`.
  - Address constants `PROG_START` = {0, 145, 290} and `PROG_DONE` = {144, 289, 435}, each PC_BITS wide.
- One sub-module, `run_counter`: a saturating counter with clear, enable and terminal-count outputs, instanced twice (START hold count and RUN count).
- The FSM and output registers live in `program_sequencer`.

## Test plan
- Reset then `go` pulse; core model asserts `done` after 50, 80 and 20 RUN cycles → three `cycle_valid` pulses with `cycle_count`=50, 80, 20. `prog_idx` reads 0, 1, 2; `all_done`=1; `timeout_err`=0.
- `core_done` held high from program 0 into START of program 1 → ignored during START; program 1 count is measured correctly.
- Core never asserts `done`, with TIMEOUT=100 → `timeout_err`=1 after 100 RUN cycles; FINISH; no `cycle_valid` for that program.
- `abort` asserted in RUN of program 1 → IDLE next cycle, `core_start`=1, `busy`=0; a new `go` restarts from `prog_idx`=0.
- `reset_n` low for one cycle mid-RUN → every output at its reset value on the next edge.
- `go` held high continuously after FINISH → no restart; a low-then-high `go` → restart, with `all_done` cleared.
